lpif_txrx_x4_asym1_half_packer: RTL and testbench

Downstream-side scheduler that feeds the asym1 half-rate LPIF link.
- Accepts one full-rate flit per cycle (state, protid, 128-bit data, dvalid, crc, crc_valid, valid) over a valid/ready handshake.
- Packs two consecutive flits into the two-slot half-rate downstream word (slot0 = low half, slot1 = high half) and presents it to the TX logic-link word mapper with a push/ready handshake.
- Flushes half-filled words on idle timeout, explicit flush, or gen-mode change.

---
 rtl/lpif_asym_pkg.sv | 33 +++
 rtl/lpif_flush_timer.sv | 38 +++
 rtl/lpif_txrx_x4_asym1_half_packer.sv | 142 ++++++++++++++
 tb/tb_lpif_txrx_x4_asym1_half_packer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_asym_pkg.sv
// Shared types for the asym1 half-rate LPIF packer: slot layout, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lpif_asym_pkg;

  localparam int LPIF_DATA_W   = 128;
  localparam int LPIF_STATE_W  = 4;
  localparam int LPIF_PROTID_W = 2;
  localparam int LPIF_CRC_W    = 4;

  // One full-rate flit; this is also the layout of one half-rate slot.
  typedef struct packed {
    logic [LPIF_STATE_W-1:0]  state;
    logic [LPIF_PROTID_W-1:0] protid;
    logic [LPIF_DATA_W-1:0]   data;
    logic                     dvalid;
    logic [LPIF_CRC_W-1:0]    crc;
    logic                     crc_valid;
    logic                     valid;
  } lpif_flit_t;

  localparam int LPIF_SLOT_W = $bits(lpif_flit_t);

  // EMPTY: no slot0 held. HALF: slot0 held in the accumulator.
  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_e;

  // Unused slots are emitted with every field cleared.
  localparam lpif_flit_t LPIF_FLIT_ZERO = '0;

endpackage

// File: rtl/lpif_flush_timer.sv
// Idle timer for a held slot0; raises flush_req on timeout or external trigger.
// Latency: flush_req is combinational from the current timer/pending state.
// Backpressure: a trigger seen while the output is busy is remembered until cleared.
module lpif_flush_timer #(
  parameter int FLUSH_TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,        // slot0 held and no flit accepted this cycle
  input  logic clr,        // slot0 leaves the accumulator (or none held)
  input  logic ext_trig,   // in_flush or gen1 mode
  input  logic out_free,
  output logic flush_req
);

  localparam int TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(FLUSH_TIMEOUT - 1);

  logic [TW-1:0] timer_q;
  logic          pending_q;

  assign flush_req = run & (ext_trig | (timer_q == T_MAX) | pending_q);

  // Saturating idle count plus sticky flush request held across output stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else if (clr) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else if (run) begin
      if (timer_q != T_MAX) timer_q <= timer_q + TW'(1);
      if (flush_req && !out_free) pending_q <= 1'b1;
    end
  end

endmodule

// File: rtl/lpif_txrx_x4_asym1_half_packer.sv
// Packs two full-rate flits into one two-slot half-rate word (slot0 = older, low half).
// Latency: gen1 1 cycle; gen2 pair 1 cycle after slot1; timeout flush FLUSH_TIMEOUT+1 after slot0.
// Backpressure: in_ready follows output-register freedom except for a gen2 slot0 accept.
module lpif_txrx_x4_asym1_half_packer
  import lpif_asym_pkg::*;
#(
  parameter int DATA_W        = LPIF_DATA_W,
  parameter int STATE_W       = LPIF_STATE_W,
  parameter int PROTID_W      = LPIF_PROTID_W,
  parameter int CRC_W         = LPIF_CRC_W,
  parameter int FLUSH_TIMEOUT = 4
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr_n,
  input  logic                  m_gen2_mode,
  input  logic                  in_flush,
  input  logic [STATE_W-1:0]    in_state,
  input  logic [PROTID_W-1:0]   in_protid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_dvalid,
  input  logic [CRC_W-1:0]      in_crc,
  input  logic                  in_crc_valid,
  input  logic                  in_valid,
  input  logic                  in_push,
  output logic                  in_ready,
  output logic [2*STATE_W-1:0]  out_state,
  output logic [2*PROTID_W-1:0] out_protid,
  output logic [2*DATA_W-1:0]   out_data,
  output logic [1:0]            out_dvalid,
  output logic [2*CRC_W-1:0]    out_crc,
  output logic [1:0]            out_crc_valid,
  output logic [1:0]            out_valid,
  output logic                  out_push,
  input  logic                  out_ready
);

  pack_state_e state_q, state_d;
  lpif_flit_t  in_flit, acc_q, slot0_q, slot1_q;
  logic        out_push_q;
  logic        out_free, accept;
  logic        acc_load, load_solo, load_pair, flush_go;
  logic        flush_req, tmr_run, tmr_clr;

  assign in_flit = '{state:     in_state,
                     protid:    in_protid,
                     data:      in_data,
                     dvalid:    in_dvalid,
                     crc:       in_crc,
                     crc_valid: in_crc_valid,
                     valid:     in_valid};

  assign out_free = !out_push_q || out_ready;

  // A gen2 slot0 only touches the accumulator, so it never waits on the output.
  assign in_ready = rst_wr_n &&
                    (((state_q == HALF) || !m_gen2_mode) ? out_free : 1'b1);
  assign accept   = in_push && in_ready;

  assign tmr_run  = (state_q == HALF) && !accept;
  assign tmr_clr  = (state_q != HALF) || accept || flush_go;
  assign flush_go = flush_req && out_free;

  lpif_flush_timer #(
    .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) u_flush_timer (
    .clk      (clk_wr),
    .rst_n    (rst_wr_n),
    .run      (tmr_run),
    .clr      (tmr_clr),
    .ext_trig (in_flush || !m_gen2_mode),
    .out_free (out_free),
    .flush_req(flush_req)
  );

  // FSM state register
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) state_q <= EMPTY;
    else           state_q <= state_d;
  end

  // Next state: gen2 slot0 accept enters HALF; any emitted word returns to EMPTY
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (acc_load) state_d = HALF;
      HALF:    if (load_pair || flush_go) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM outputs: which register load happens this cycle (accept beats flush in HALF)
  always_comb begin
    acc_load  = 1'b0;
    load_solo = 1'b0;
    load_pair = 1'b0;
    case (state_q)
      EMPTY: begin
        acc_load  = accept && m_gen2_mode;
        load_solo = accept && !m_gen2_mode;
      end
      HALF:    load_pair = accept;
      default: ;
    endcase
  end

  // Accumulator and output word register; the push flag drops once consumed
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      acc_q      <= LPIF_FLIT_ZERO;
      slot0_q    <= LPIF_FLIT_ZERO;
      slot1_q    <= LPIF_FLIT_ZERO;
      out_push_q <= 1'b0;
    end else begin
      if (acc_load) acc_q <= in_flit;
      if (load_solo) begin
        slot0_q    <= in_flit;
        slot1_q    <= LPIF_FLIT_ZERO;
        out_push_q <= 1'b1;
      end else if (load_pair) begin
        slot0_q    <= acc_q;
        slot1_q    <= in_flit;
        out_push_q <= 1'b1;
      end else if (flush_go) begin
        slot0_q    <= acc_q;
        slot1_q    <= LPIF_FLIT_ZERO;
        out_push_q <= 1'b1;
      end else if (out_ready) begin
        out_push_q <= 1'b0;
      end
    end
  end

  assign out_push      = out_push_q;
  assign out_state     = {slot1_q.state,     slot0_q.state};
  assign out_protid    = {slot1_q.protid,    slot0_q.protid};
  assign out_data      = {slot1_q.data,      slot0_q.data};
  assign out_dvalid    = {slot1_q.dvalid,    slot0_q.dvalid};
  assign out_crc       = {slot1_q.crc,       slot0_q.crc};
  assign out_crc_valid = {slot1_q.crc_valid, slot0_q.crc_valid};
  assign out_valid     = {slot1_q.valid,     slot0_q.valid};

endmodule

// File: tb/tb_lpif_txrx_x4_asym1_half_packer.sv
// Bench for the half-rate packer: directed scenarios plus random traffic.
// Latency: expected words are queued by a transaction model and popped by a monitor.
// Backpressure: out_ready is randomly deasserted to exercise stalls and pending flushes.
module tb_lpif_txrx_x4_asym1_half_packer;
  import lpif_asym_pkg::*;

  localparam int FT = 4;
  localparam int WW = 2 * LPIF_SLOT_W;
  localparam int CW = 300;

  logic clk = 1'b0;
  logic rst_n, gen2, flush, push, ready;
  lpif_flit_t fin;
  logic in_ready, out_push;
  logic [2*LPIF_STATE_W-1:0]  out_state;
  logic [2*LPIF_PROTID_W-1:0] out_protid;
  logic [2*LPIF_DATA_W-1:0]   out_data;
  logic [1:0] out_dvalid, out_crc_valid, out_valid;
  logic [2*LPIF_CRC_W-1:0] out_crc;

  int tests = 0;
  int fails = 0;
  logic [WW-1:0] exp_q[$];

  bit m_half, m_pend, m_ofull;
  int m_age;
  lpif_flit_t m_hold;
  lpif_flit_t f0, f1, f2, f3;

  always #5 clk = ~clk;

  lpif_txrx_x4_asym1_half_packer #(.FLUSH_TIMEOUT(FT)) dut (
    .clk_wr(clk), .rst_wr_n(rst_n), .m_gen2_mode(gen2), .in_flush(flush),
    .in_state(fin.state), .in_protid(fin.protid), .in_data(fin.data),
    .in_dvalid(fin.dvalid), .in_crc(fin.crc), .in_crc_valid(fin.crc_valid),
    .in_valid(fin.valid), .in_push(push), .in_ready(in_ready),
    .out_state(out_state), .out_protid(out_protid), .out_data(out_data),
    .out_dvalid(out_dvalid), .out_crc(out_crc), .out_crc_valid(out_crc_valid),
    .out_valid(out_valid), .out_push(out_push), .out_ready(ready));

  wire [WW-1:0] act_word = {out_state, out_protid, out_data, out_dvalid,
                            out_crc, out_crc_valid, out_valid};

  function automatic logic [WW-1:0] mkword(input lpif_flit_t s1, input lpif_flit_t s0);
    return {s1.state, s0.state, s1.protid, s0.protid, s1.data, s0.data,
            s1.dvalid, s0.dvalid, s1.crc, s0.crc, s1.crc_valid, s0.crc_valid,
            s1.valid, s0.valid};
  endfunction

  function automatic lpif_flit_t rnd_flit(input logic [LPIF_DATA_W-1:0] d, input bit v);
    lpif_flit_t f;
    f.state     = LPIF_STATE_W'($urandom);
    f.protid    = LPIF_PROTID_W'($urandom);
    f.data      = d;
    f.dvalid    = 1'($urandom);
    f.crc       = LPIF_CRC_W'($urandom);
    f.crc_valid = 1'($urandom);
    f.valid     = v;
    return f;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: an output slot that is full or empty, and an optional held slot0
  // with its idle age; each cycle decides acceptance and which word (if any) is emitted.
  always @(negedge clk) begin : model
    bit free, rdy, took, trig, load;
    if (!rst_n) begin
      chk("rst_in_ready", CW'(in_ready), CW'(0));
      m_half = 0; m_pend = 0; m_ofull = 0; m_age = 0;
      exp_q.delete();
    end else begin
      free = !m_ofull || ready;
      rdy  = (m_half || !gen2) ? free : 1'b1;
      chk("in_ready", CW'(in_ready), CW'(rdy));
      chk("out_push", CW'(out_push), CW'(m_ofull));
      took = push && rdy;
      load = 0;
      if (!m_half) begin
        if (took && gen2) begin
          m_half = 1; m_hold = fin; m_age = 0; m_pend = 0;
        end else if (took) begin
          exp_q.push_back(mkword(LPIF_FLIT_ZERO, fin)); load = 1;
        end
      end else if (took) begin
        exp_q.push_back(mkword(fin, m_hold)); load = 1; m_half = 0;
      end else begin
        trig = (m_age == FT - 1) || flush || !gen2 || m_pend;
        if (trig && free) begin
          exp_q.push_back(mkword(LPIF_FLIT_ZERO, m_hold)); load = 1; m_half = 0;
        end else begin
          if (trig) m_pend = 1;
          if (m_age < FT - 1) m_age++;
        end
      end
      if (load) m_ofull = 1;
      else if (ready) m_ofull = 0;
    end
  end

  // Monitor: every consumed word must be the oldest expected one
  always @(negedge clk) begin : monitor
    if (rst_n && out_push === 1'b1 && ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_word: got %0h, expected none", act_word);
      end else begin
        chk("word", CW'(act_word), CW'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input lpif_flit_t f);
    int n;
    n = 0;
    push = 1; fin = f;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      step(1);
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout: got no in_ready, expected in_ready within 200 cycles");
        push = 0;
        return;
      end
    end
    step(1);
    push = 0;
  endtask

  initial begin
    rst_n = 0; gen2 = 1; flush = 0; push = 0; ready = 1;
    fin = LPIF_FLIT_ZERO;
    @(posedge clk); @(negedge clk);
    chk("reset_outputs", CW'({out_push, act_word}), CW'(0));
    step(1); rst_n = 1;
    step(2);

    // gen2 pair: A0, A1 back to back appear as one word two cycles after A0
    f0 = rnd_flit(128'hA0, 1); f1 = rnd_flit(128'hA1, 1);
    send(f0); send(f1);
    @(negedge clk);
    chk("pair_word", CW'({out_push, out_valid, out_data}), CW'({1'b1, 2'b11, f1.data, f0.data}));
    step(6);

    // lone slot0 emitted after the idle timeout, slot1 fields all zero
    f0 = rnd_flit(128'hB0, 1);
    send(f0);
    for (int i = 1; i < FT + 1; i++) begin
      @(negedge clk);
      chk("timeout_not_yet", CW'(out_push), CW'(0));
      step(1);
    end
    @(negedge clk);
    chk("timeout_word", CW'({out_push, act_word}), CW'({1'b1, mkword(LPIF_FLIT_ZERO, f0)}));
    step(6);

    // output stall with four flits: first word held, fourth flit waits
    f0 = rnd_flit(128'h10, 1); f1 = rnd_flit(128'h11, 1);
    f2 = rnd_flit(128'h12, 1); f3 = rnd_flit(128'h13, 1);
    ready = 0;
    fork
      begin send(f0); send(f1); send(f2); send(f3); end
      begin
        repeat (9) @(negedge clk);
        chk("stall_held_word", CW'({out_push, out_valid, out_data}), CW'({1'b1, 2'b11, f1.data, f0.data}));
        chk("stall_in_ready", CW'(in_ready), CW'(0));
        step(1);
        ready = 1;
      end
    join
    step(8);

    // accept arriving exactly at timer saturation wins over the timeout
    f0 = rnd_flit(128'hD0, 1); f1 = rnd_flit(128'hD1, 1);
    send(f0); step(FT - 1); send(f1);
    @(negedge clk);
    chk("race_full_word", CW'({out_push, out_valid, out_data}), CW'({1'b1, 2'b11, f1.data, f0.data}));
    step(1);
    @(negedge clk);
    chk("race_no_solo", CW'(out_push), CW'(0));
    step(4);

    // gen2 -> gen1 while slot0 held flushes it; gen1 flits then go out one per word
    f0 = rnd_flit(128'hC0, 1);
    send(f0);
    gen2 = 0;
    step(1);
    @(negedge clk);
    chk("mode_flush_word", CW'({out_push, out_valid, out_data}), CW'({1'b1, 2'b01, 128'h0, f0.data}));
    step(1);
    f1 = rnd_flit(128'hC1, 1); f2 = rnd_flit(128'hC2, 1);
    send(f1); send(f2);
    @(negedge clk);
    chk("gen1_solo_word", CW'(act_word), CW'(mkword(LPIF_FLIT_ZERO, f2)));
    step(4);
    gen2 = 1;

    // reset while a word is held and slot0 is accumulated discards both
    ready = 0;
    send(rnd_flit(128'hE0, 1)); send(rnd_flit(128'hE1, 1)); send(rnd_flit(128'hE2, 1));
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", CW'(in_ready), CW'(0));
    step(1);
    rst_n = 1; ready = 1;
    @(negedge clk);
    chk("post_rst_outputs", CW'({out_push, act_word}), CW'(0));
    step(1);
    f0 = rnd_flit(128'hF0, 1); f1 = rnd_flit(128'hF1, 1);
    send(f0); send(f1);
    @(negedge clk);
    chk("post_rst_word", CW'({out_push, act_word}), CW'({1'b1, mkword(f1, f0)}));
    step(4);

    // random traffic, stalls, flushes, mode changes and rare resets
    for (int c = 0; c < 3000; c++) begin
      push  = ($urandom_range(0, 2) != 0);
      fin   = rnd_flit({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 7) != 0));
      flush = ($urandom_range(0, 15) == 0);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) gen2 = ~gen2;
      rst_n = ($urandom_range(0, 499) != 0);
      step(1);
    end

    rst_n = 1; push = 0; flush = 0; ready = 1; gen2 = 1;
    step(20);
    chk("drain_queue_empty", CW'(exp_q.size()), CW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
